fx3_packet_source: RTL and testbench

- Upstream data stage for the FX3 GPIF read state machine, in the FX3 clock domain.
- Drains 10-bit RF samples from the read side of the sample FIFO, which is a show-ahead dual-clock FIFO.
- Presents each sample as a 16-bit word on the GPIF data bus while fx3isReading is high.
- Raises dataAvailable once a full packet is buffered; tracks packet count and underflow.

---
 rtl/fx3_packet_source.sv | 189 ++++++++++++++++++
 tb/tb_fx3_packet_source.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_packet_source.sv
// fx3_packet_source
// Upstream data stage for the FX3 GPIF read state machine (FX3 clock domain).
// Drains 10-bit samples from a show-ahead dual-clock FIFO and presents them,
// zero-extended, as 16-bit words on the GPIF data bus while the downstream
// machine is reading. Flags packet availability, counts completed packets and
// records FIFO starvation.
//
// Optional build macro: TEST_PATTERN_EN
//   Adds the testMode input. With testMode=1 the FIFO is ignored and words come
//   from an internal 10-bit wrapping counter; dataAvailable is 1 whenever idle.
//
// Ports:
//   fx3_clock        in   GPIF clock, all logic on the rising edge
//   nReset           in   synchronous active-low reset
//   fx3isReading     in   downstream machine is transferring a packet
//   fifoRdData[9:0]  in   FIFO head sample (valid while fifoRdEmpty=0)
//   fifoRdEmpty      in   FIFO empty flag
//   fifoUsedWords    in   FIFO read-side fill level
//   testMode         in   (TEST_PATTERN_EN only) select internal pattern source
//   fifoRdReq        out  combinational FIFO read acknowledge (pops head)
//   fx3Data[15:0]    out  GPIF data word, one cycle after the consuming cycle
//   dataAvailable    out  a full packet is buffered and the block is idle
//   bufferUnderflow  out  sticky: FIFO was empty during a read slot
//   packetCount      out  completed packets, wrapping
module fx3_packet_source #(
  parameter int unsigned PACKET_WORDS    = 8192,
  parameter int unsigned AVAIL_THRESHOLD = 8192,
  parameter int unsigned USEDW_WIDTH     = 16
) (
  input  logic                   fx3_clock,
  input  logic                   nReset,
  input  logic                   fx3isReading,
  input  logic [9:0]             fifoRdData,
  input  logic                   fifoRdEmpty,
  input  logic [USEDW_WIDTH-1:0] fifoUsedWords,
`ifdef TEST_PATTERN_EN
  input  logic                   testMode,
`endif
  output logic                   fifoRdReq,
  output logic [15:0]            fx3Data,
  output logic                   dataAvailable,
  output logic                   bufferUnderflow,
  output logic [15:0]            packetCount
);

  localparam int unsigned WC_W     = 16;
  localparam int unsigned PC_W     = 16;
  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PAD_W    = DATA_W - SAMPLE_W;

  // Index of the final word of a packet; reaching it closes the packet.
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(PACKET_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  state_e              state_q,        state_d;
  logic [WC_W-1:0]     word_count_q,   word_count_d;
  logic [PC_W-1:0]     packet_count_q, packet_count_d;
  logic [DATA_W-1:0]   fx3_data_q,     fx3_data_d;
  logic                data_avail_q,   data_avail_d;
  logic                underflow_q,    underflow_d;
`ifdef TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] pattern_q,      pattern_d;
  logic                pattern_slot_c;
`endif

  logic slot_c;         // a read slot: downstream reading and not in the gap
  logic pop_c;          // slot served from the FIFO head
  logic starve_c;       // slot with nothing to serve from the FIFO
  logic avail_level_c;  // FIFO holds at least a threshold's worth of words

  // Slot classification; the pattern source, when selected, hides the FIFO.
  always_comb begin
    slot_c = fx3isReading && (state_q != S_GAP);
`ifdef TEST_PATTERN_EN
    pop_c          = slot_c && !testMode && !fifoRdEmpty;
    starve_c       = slot_c && !testMode && fifoRdEmpty;
    pattern_slot_c = slot_c && testMode;
`else
    pop_c          = slot_c && !fifoRdEmpty;
    starve_c       = slot_c && fifoRdEmpty;
`endif
  end

  assign avail_level_c = (32'(fifoUsedWords) >= AVAIL_THRESHOLD);

  // The FIFO must never be popped while this block is held in reset.
  assign fifoRdReq = nReset && pop_c;

  // Packet framing FSM: next state, word and packet counters.
  always_comb begin
    state_d        = state_q;
    word_count_d   = word_count_q;
    packet_count_d = packet_count_q;

    unique case (state_q)
      S_IDLE, S_STREAM: begin
        if (slot_c) begin
          // Every slot counts, starved or not, so packet length is fixed.
          if (word_count_q == LAST_WORD) begin
            state_d        = S_GAP;
            word_count_d   = '0;
            packet_count_d = packet_count_q + PC_W'(1);
          end else begin
            state_d      = S_STREAM;
            word_count_d = word_count_q + WC_W'(1);
          end
        end else begin
          // Reading stopped mid-packet: drop the partial packet.
          state_d      = S_IDLE;
          word_count_d = '0;
        end
      end
      S_GAP: begin
        state_d      = S_IDLE;
        word_count_d = '0;
      end
      default: begin
        state_d      = S_IDLE;
        word_count_d = '0;
      end
    endcase
  end

  // Data word, underflow flag, availability flag and pattern counter.
  always_comb begin
    fx3_data_d  = fx3_data_q;
    underflow_d = underflow_q;
`ifdef TEST_PATTERN_EN
    pattern_d   = pattern_q;
`endif

    if (pop_c) begin
      fx3_data_d = {{PAD_W{1'b0}}, fifoRdData};
    end else if (starve_c) begin
      fx3_data_d  = '0;
      underflow_d = 1'b1;
    end
`ifdef TEST_PATTERN_EN
    if (pattern_slot_c) begin
      fx3_data_d = {{PAD_W{1'b0}}, pattern_q};
      pattern_d  = pattern_q + SAMPLE_W'(1);
    end
`endif

    // Judged on the state being entered so the flag drops as streaming starts.
`ifdef TEST_PATTERN_EN
    data_avail_d = (state_d == S_IDLE) && (testMode || avail_level_c);
`else
    data_avail_d = (state_d == S_IDLE) && avail_level_c;
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge fx3_clock) begin
    if (!nReset) begin
      state_q        <= S_IDLE;
      word_count_q   <= '0;
      packet_count_q <= '0;
      fx3_data_q     <= '0;
      data_avail_q   <= 1'b0;
      underflow_q    <= 1'b0;
`ifdef TEST_PATTERN_EN
      pattern_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      word_count_q   <= word_count_d;
      packet_count_q <= packet_count_d;
      fx3_data_q     <= fx3_data_d;
      data_avail_q   <= data_avail_d;
      underflow_q    <= underflow_d;
`ifdef TEST_PATTERN_EN
      pattern_q      <= pattern_d;
`endif
    end
  end

  assign fx3Data         = fx3_data_q;
  assign dataAvailable   = data_avail_q;
  assign bufferUnderflow = underflow_q;
  assign packetCount     = packet_count_q;

endmodule

// File: tb/tb_fx3_packet_source.sv
// Self-checking bench for fx3_packet_source. A queue-based FIFO model feeds the
// DUT; a packet-level reference model predicts words, read requests and flags.
module tb_fx3_packet_source;

  localparam int PW         = 8192;
  localparam int AVAIL      = 8192;
  localparam int FILL_LEVEL = 9000;

  logic        clk = 1'b0;
  logic        nReset;
  logic        fx3isReading;
  logic [9:0]  fifoRdData;
  logic        fifoRdEmpty;
  logic [15:0] fifoUsedWords;
  logic        fifoRdReq;
  logic [15:0] fx3Data;
  logic        dataAvailable;
  logic        bufferUnderflow;
  logic [15:0] packetCount;
  logic        test_mode_on;

  fx3_packet_source #(
    .PACKET_WORDS   (PW),
    .AVAIL_THRESHOLD(AVAIL),
    .USEDW_WIDTH    (16)
  ) dut (
    .fx3_clock      (clk),
    .nReset         (nReset),
    .fx3isReading   (fx3isReading),
    .fifoRdData     (fifoRdData),
    .fifoRdEmpty    (fifoRdEmpty),
    .fifoUsedWords  (fifoUsedWords),
`ifdef TEST_PATTERN_EN
    .testMode       (test_mode_on),
`endif
    .fifoRdReq      (fifoRdReq),
    .fx3Data        (fx3Data),
    .dataAvailable  (dataAvailable),
    .bufferUnderflow(bufferUnderflow),
    .packetCount    (packetCount)
  );

  always #5 clk = ~clk;

  // FIFO contents as the DUT sees them, and the model's private copy.
  logic [9:0]  fifo_q[$];
  logic [9:0]  exp_q[$];
  int          fill_level;
  bit          fill_random;
  int          fill_cnt;
  bit          used_ovr_en;
  logic [15:0] used_ovr;

  // Packet-level reference model state.
  int          m_slots;
  bit          m_gap;
  logic [15:0] m_pkt;
  logic        m_uf;
  logic [15:0] m_data;
  logic [9:0]  m_pat;
  logic        m_req;
  logic        m_da;
  logic        last_req;

  int n_checks;
  int n_fail;

  // One clock: drive at negedge, predict, sample fifoRdReq, pop on posedge.
  task automatic tick(input logic rd, input logic fe);
    logic       empty_now;
    logic [9:0] v;
    bit         idle_next;
    @(negedge clk);
    while (fifo_q.size() < fill_level) begin
      v = fill_random ? 10'($urandom) : 10'(fill_cnt % 1024);
      fill_cnt++;
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    empty_now     = fe || (fifo_q.size() == 0);
    fx3isReading  = rd;
    fifoRdEmpty   = empty_now;
    fifoRdData    = (fifo_q.size() != 0) ? fifo_q[0] : 10'd0;
    fifoUsedWords = used_ovr_en ? used_ovr : 16'(fifo_q.size());
    if (!nReset) begin
      m_slots = 0; m_gap = 0; m_pkt = 16'd0; m_uf = 1'b0;
      m_data = 16'd0; m_pat = 10'd0; m_req = 1'b0; m_da = 1'b0;
    end else begin
      m_req = 1'b0;
      if (m_gap) begin
        m_gap = 0;
      end else if (rd) begin
        if (test_mode_on) begin
          m_data = {6'd0, m_pat};
          m_pat  = m_pat + 10'd1;
        end else if (empty_now) begin
          m_data = 16'd0;
          m_uf   = 1'b1;
        end else begin
          m_req  = 1'b1;
          m_data = (exp_q.size() != 0) ? {6'd0, exp_q.pop_front()} : 16'hFFFF;
        end
        m_slots++;
        if (m_slots == PW) begin
          m_slots = 0;
          m_gap   = 1;
          m_pkt   = m_pkt + 16'd1;
        end
      end else begin
        m_slots = 0;
      end
      idle_next = !m_gap && (m_slots == 0);
      m_da = idle_next && (test_mode_on || (int'(fifoUsedWords) >= AVAIL));
    end
    #1 last_req = fifoRdReq;
    @(posedge clk);
    if (last_req === 1'b1) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_checks++;
    if (last_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdreq: got %b expected 0", last_req);
    end
    n_checks++;
    if ({fx3Data, dataAvailable, bufferUnderflow, packetCount} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data %h avail %b uf %b pkt %h expected all 0",
               fx3Data, dataAvailable, bufferUnderflow, packetCount);
    end
    nReset = 1'b1;
    tick(1'b0, 1'b0);
    n_checks++;
    if (dataAvailable !== 1'b1) begin
      n_fail++; $display("FAIL release_avail: got %b expected 1", dataAvailable);
    end
    n_checks++;
    if (fx3Data !== 16'h0000 || last_req !== 1'b0) begin
      n_fail++; $display("FAIL release_idle: got data %h req %b expected 0000 0", fx3Data, last_req);
    end
  endtask

  task automatic test_full_packet();
    int errs = 0, first = -1, reqs = 0;
    logic [15:0] got_first = 0, exp_first = 0;
    for (int k = 0; k < PW; k++) begin
      tick(1'b1, 1'b0);
      reqs += int'(last_req);
      if (fx3Data !== m_data || last_req !== m_req || dataAvailable !== 1'b0 ||
          packetCount !== ((k == PW - 1) ? 16'd1 : 16'd0)) begin
        if (first < 0) begin first = k; got_first = fx3Data; exp_first = m_data; end
        errs++;
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL full_seq: %0d bad cycles, first slot %0d got data %h expected %h",
               errs, first, got_first, exp_first);
    end
    n_checks++;
    if (reqs != PW) begin
      n_fail++; $display("FAIL full_req_cycles: got %0d expected %0d", reqs, PW);
    end
    n_checks++;
    if (fx3Data !== 16'd1023) begin
      n_fail++; $display("FAIL full_last_word: got %h expected 03ff", fx3Data);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (last_req !== 1'b0 || fx3Data !== 16'd1023) begin
      n_fail++; $display("FAIL gap_cycle: got req %b data %h expected 0 03ff", last_req, fx3Data);
    end
    n_checks++;
    if (dataAvailable !== 1'b1) begin
      n_fail++; $display("FAIL gap_exit_avail: got %b expected 1", dataAvailable);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (packetCount !== 16'd1) begin
      n_fail++; $display("FAIL full_pkt_count: got %0d expected 1", packetCount);
    end
  endtask

  task automatic test_underflow();
    int errs = 0, first = -1, reqs = 0, zero_errs = 0;
    logic uf_before = 1'bx, uf_at = 1'bx;
    fill_random = 1;
    for (int k = 0; k < PW; k++) begin
      tick(1'b1, (k >= 100 && k <= 102));
      reqs += int'(last_req);
      if (k == 99)  uf_before = bufferUnderflow;
      if (k == 100) uf_at = bufferUnderflow;
      if (k >= 100 && k <= 102 && fx3Data !== 16'h0000) zero_errs++;
      if (fx3Data !== m_data || last_req !== m_req || bufferUnderflow !== m_uf ||
          packetCount !== m_pkt) begin
        if (first < 0) first = k;
        errs++;
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL uf_seq: %0d bad cycles, first slot %0d", errs, first);
    end
    n_checks++;
    if (zero_errs != 0) begin
      n_fail++; $display("FAIL uf_zero_words: got %0d nonzero starved words expected 0", zero_errs);
    end
    n_checks++;
    if (uf_before !== 1'b0 || uf_at !== 1'b1) begin
      n_fail++; $display("FAIL uf_flag_edge: got %b->%b expected 0->1", uf_before, uf_at);
    end
    n_checks++;
    if (reqs != PW - 3) begin
      n_fail++; $display("FAIL uf_req_cycles: got %0d expected %0d", reqs, PW - 3);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (packetCount !== 16'd2) begin
      n_fail++; $display("FAIL uf_pkt_count: got %0d expected 2", packetCount);
    end
    n_checks++;
    if (bufferUnderflow !== 1'b1) begin
      n_fail++; $display("FAIL uf_sticky: got %b expected 1", bufferUnderflow);
    end
  endtask

  task automatic test_abort();
    int errs = 0, first = -1, reqs = 0;
    for (int k = 0; k < 500; k++) begin
      tick(1'b1, 1'b0);
      if (fx3Data !== m_data || last_req !== m_req || packetCount !== 16'd2) begin
        if (first < 0) first = k;
        errs++;
      end
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (dataAvailable !== 1'b1 || packetCount !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_idle: got avail %b pkt %0d expected 1 2", dataAvailable, packetCount);
    end
    for (int k = 0; k < PW; k++) begin
      tick(1'b1, 1'b0);
      reqs += int'(last_req);
      if (fx3Data !== m_data || last_req !== m_req || dataAvailable !== m_da ||
          packetCount !== m_pkt) begin
        if (first < 0) first = 500 + k;
        errs++;
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL abort_seq: %0d bad cycles, first at %0d", errs, first);
    end
    n_checks++;
    if (reqs != PW) begin
      n_fail++; $display("FAIL abort_refetch_reqs: got %0d expected %0d", reqs, PW);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (packetCount !== 16'd3) begin
      n_fail++; $display("FAIL abort_pkt_count: got %0d expected 3", packetCount);
    end
  endtask

  task automatic test_threshold();
    logic [15:0] levels[6] = '{16'd8191, 16'd8192, 16'd8191, 16'd0, 16'hFFFF, 16'd8193};
    logic        want;
    used_ovr_en = 1;
    for (int i = 0; i < 6; i++) begin
      used_ovr = levels[i];
      want = (int'(levels[i]) >= AVAIL);
      tick(1'b0, 1'b0);
      n_checks++;
      if (dataAvailable !== want) begin
        n_fail++;
        $display("FAIL threshold_%0d: got %b expected %b", levels[i], dataAvailable, want);
      end
    end
    used_ovr_en = 0;
  endtask

  task automatic test_reset_mid_packet();
    int sz;
    for (int k = 0; k < 300; k++) tick(1'b1, 1'b0);
    nReset = 1'b0;
    fill_level = 0;
    sz = fifo_q.size();
    tick(1'b1, 1'b0);
    n_checks++;
    if (last_req !== 1'b0 || fifo_q.size() != sz) begin
      n_fail++;
      $display("FAIL midreset_no_pop: got req %b fifo %0d expected 0 %0d", last_req, fifo_q.size(), sz);
    end
    n_checks++;
    if ({fx3Data, dataAvailable, bufferUnderflow, packetCount} !== 34'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got data %h avail %b uf %b pkt %h expected all 0",
               fx3Data, dataAvailable, bufferUnderflow, packetCount);
    end
    nReset = 1'b1;
    fill_level = FILL_LEVEL;
    tick(1'b0, 1'b0);
    n_checks++;
    if (dataAvailable !== 1'b1 || packetCount !== 16'd0 || bufferUnderflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got avail %b pkt %0d uf %b expected 1 0 0",
               dataAvailable, packetCount, bufferUnderflow);
    end
  endtask

  task automatic test_random();
    int errs = 0, first = -1, cyc = 0, seg = 0, run, idle;
    fill_random = 1;
    used_ovr_en = 1;
    while (cyc < 12000) begin
      run  = (seg == 0 || $urandom_range(0, 3) == 0) ? PW + 1 : int'($urandom_range(1, 400));
      idle = int'($urandom_range(1, 4));
      for (int k = 0; k < run + idle; k++) begin
        used_ovr = 16'($urandom_range(AVAIL - 8, AVAIL + 8));
        tick(k < run, $urandom_range(0, 49) == 0);
        if (fx3Data !== m_data || last_req !== m_req || dataAvailable !== m_da ||
            bufferUnderflow !== m_uf || packetCount !== m_pkt) begin
          if (first < 0) first = cyc + k;
          errs++;
        end
      end
      cyc += run + idle;
      seg++;
    end
    used_ovr_en = 0;
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL random_seq: %0d bad cycles, first at %0d", errs, first);
    end
    n_checks++;
    if (packetCount !== m_pkt || bufferUnderflow !== m_uf) begin
      n_fail++;
      $display("FAIL random_final: got pkt %0d uf %b expected %0d %b",
               packetCount, bufferUnderflow, m_pkt, m_uf);
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    int errs = 0, seq_errs = 0, reqs = 0, idx = 0;
    nReset = 1'b0;
    tick(1'b0, 1'b0);
    test_mode_on = 1'b1;
    nReset = 1'b1;
    used_ovr_en = 1;
    used_ovr = 16'd0;
    tick(1'b0, 1'b0);
    n_checks++;
    if (dataAvailable !== 1'b1) begin
      n_fail++; $display("FAIL pattern_avail: got %b expected 1", dataAvailable);
    end
    for (int k = 0; k < 2 * (PW + 1); k++) begin
      tick(1'b1, (k % 97) == 0);
      reqs += int'(last_req);
      if (k != PW && k != 2 * PW + 1) begin
        if (fx3Data !== 16'(idx % 1024)) seq_errs++;
        idx++;
      end
      if (fx3Data !== m_data || dataAvailable !== m_da || bufferUnderflow !== 1'b0) errs++;
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (seq_errs != 0 || errs != 0) begin
      n_fail++; $display("FAIL pattern_seq: got %0d/%0d bad words expected 0", seq_errs, errs);
    end
    n_checks++;
    if (reqs != 0) begin
      n_fail++; $display("FAIL pattern_no_fifo_req: got %0d expected 0", reqs);
    end
    n_checks++;
    if (packetCount !== 16'd2) begin
      n_fail++; $display("FAIL pattern_pkt_count: got %0d expected 2", packetCount);
    end
    test_mode_on = 1'b0;
    used_ovr_en = 0;
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    nReset = 1'b0; fx3isReading = 1'b0; fifoRdEmpty = 1'b1;
    fifoRdData = 10'd0; fifoUsedWords = 16'd0; test_mode_on = 1'b0;
    fill_level = FILL_LEVEL; fill_random = 0; fill_cnt = 0;
    used_ovr_en = 0; used_ovr = 16'd0; last_req = 1'b0;
    m_slots = 0; m_gap = 0; m_pkt = 16'd0; m_uf = 1'b0;
    m_data = 16'd0; m_pat = 10'd0; m_req = 1'b0; m_da = 1'b0;

    test_reset();
    test_full_packet();
    test_underflow();
    test_abort();
    test_threshold();
    test_reset_mid_packet();
    test_random();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
